// File: rtl/interp_timing_ctrl.sv
// Symbol-timing interpolator controller: a modulo-1 decrementing NCO that produces interpolate
// strobes, the fractional interval mu and on-time/mid-symbol markers for a timing-recovery loop.
module interp_timing_ctrl #(
    parameter int unsigned SETTLE_CNT = 8,
    parameter logic [15:0] W_MIN      = 16'h6000,
    parameter logic [15:0] W_MAX      = 16'hA000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               sample_valid,
    input  logic signed [15:0] w_in,
    input  logic               w_valid,
    output logic               interpolator_en,
    output logic        [15:0] f,
    output logic               symbol_strobe,
    output logic               mid_strobe,
    output logic        [1:0]  state
);

    localparam logic [15:0] W_NOM    = 16'h8000;
    localparam logic [15:0] ETA_INIT = 16'hFFFF;
    localparam int unsigned CNT_W    = $clog2(SETTLE_CNT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((SETTLE_CNT == 0) ? 0 : SETTLE_CNT - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSettle = 2'b01,
        StTrack  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      eta_q, eta_d;
    logic [15:0]      w_q, w_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      f_q, f_d;
    logic             ie_q, ie_d;
    logic             sym_q, sym_d;
    logic             mid_q, mid_d;

    logic               accept;
    logic               in_track;
    logic [16:0]        diff;
    logic               underflow;
    logic [16:0]        eta_x2;
    logic [15:0]        f_sat;
    logic signed [17:0] w_sum;
    logic signed [17:0] w_min_s;
    logic signed [17:0] w_max_s;
    logic [15:0]        w_clamped;

    assign in_track  = (state_q == StTrack);
    assign accept    = sample_valid && ((state_q == StSettle) || in_track);

    // Borrow out of the 17-bit subtraction marks an NCO wrap.
    assign diff      = {1'b0, eta_q} - {1'b0, w_q};
    assign underflow = diff[16];

    // mu = eta_old / W with W nominally one half, approximated as 2*eta and saturated.
    assign eta_x2    = {eta_q, 1'b0};
    assign f_sat     = eta_x2[16] ? 16'hFFFF : eta_x2[15:0];

    assign w_sum     = 18'sh08000 + {{2{w_in[15]}}, w_in};
    assign w_min_s   = $signed({2'b00, W_MIN});
    assign w_max_s   = $signed({2'b00, W_MAX});
    assign w_clamped = (w_sum < w_min_s) ? W_MIN :
                       (w_sum > w_max_s) ? W_MAX : w_sum[15:0];

    always_comb begin
        state_d = state_q;
        eta_d   = eta_q;
        w_d     = w_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        ie_d    = 1'b0;
        sym_d   = 1'b0;
        mid_d   = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            eta_d   = ETA_INIT;
            w_d     = W_NOM;
            phase_d = 1'b0;
            cnt_d   = '0;
            f_d     = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSettle;
                end
                StSettle: begin
                    if (sample_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q >= CNT_LAST) begin
                            state_d = StTrack;
                        end
                    end
                end
                StTrack: begin
                    // A coincident sample still uses w_q; the new step applies next sample.
                    if (w_valid) begin
                        w_d = w_clamped;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (accept) begin
                eta_d = diff[15:0];
                if (underflow) begin
                    ie_d    = 1'b1;
                    f_d     = f_sat;
                    phase_d = ~phase_q;
                    sym_d   = in_track && !phase_q;
                    mid_d   = in_track && phase_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            eta_q   <= ETA_INIT;
            w_q     <= W_NOM;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            f_q     <= '0;
            ie_q    <= 1'b0;
            sym_q   <= 1'b0;
            mid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            eta_q   <= eta_d;
            w_q     <= w_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            ie_q    <= ie_d;
            sym_q   <= sym_d;
            mid_q   <= mid_d;
        end
    end

    assign interpolator_en = ie_q;
    assign f               = f_q;
    assign symbol_strobe   = sym_q;
    assign mid_strobe      = mid_q;
    assign state           = state_q;

endmodule

// File: tb/tb_interp_timing_ctrl.sv
// Bench for interp_timing_ctrl: directed scenarios plus randomized traffic, all checked
// cycle by cycle against an arithmetic reference model of the timing NCO.
module tb_interp_timing_ctrl;

    localparam int SETTLE = 8;
    localparam int WMIN   = 'h6000;
    localparam int WMAX   = 'hA000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] w_in = '0;
    logic        w_valid = 1'b0;
    logic        interpolator_en;
    logic [15:0] f;
    logic        symbol_strobe;
    logic        mid_strobe;
    logic [1:0]  state;

    interp_timing_ctrl #(
        .SETTLE_CNT (SETTLE),
        .W_MIN      (16'h6000),
        .W_MAX      (16'hA000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .sample_valid    (sample_valid),
        .w_in            (w_in),
        .w_valid         (w_valid),
        .interpolator_en (interpolator_en),
        .f               (f),
        .symbol_strobe   (symbol_strobe),
        .mid_strobe      (mid_strobe),
        .state           (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: plain integers, 0=idle 1=settle 2=track.
    int m_state = 0;
    int m_eta   = 'hFFFF;
    int m_w     = 'h8000;
    int m_ph    = 0;
    int m_cnt   = 0;
    int m_f     = 0;
    int m_ie    = 0;
    int m_sym   = 0;
    int m_mid   = 0;
    bit en_cur  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit en, input bit sv, input bit wv,
                         input logic [15:0] win);
        int d;
        int s;
        int old_state;
        reset        = rst;
        enable       = en;
        sample_valid = sv;
        w_valid      = wv;
        w_in         = win;

        old_state = m_state;
        m_ie  = 0;
        m_sym = 0;
        m_mid = 0;
        if (!rst || !en) begin
            m_state = 0;
            m_eta   = 'hFFFF;
            m_w     = 'h8000;
            m_ph    = 0;
            m_cnt   = 0;
            m_f     = 0;
        end else if (old_state == 0) begin
            m_state = 1;
        end else begin
            if (sv) begin
                d = m_eta - m_w;
                if (d < 0) begin
                    m_ie = 1;
                    m_f  = (2 * m_eta > 'hFFFF) ? 'hFFFF : 2 * m_eta;
                    if (old_state == 2) begin
                        m_sym = (m_ph == 0) ? 1 : 0;
                        m_mid = (m_ph == 1) ? 1 : 0;
                    end
                    m_ph = 1 - m_ph;
                    d    = d + 65536;
                end
                m_eta = d;
                if (old_state == 1) begin
                    m_cnt++;
                    if (m_cnt >= SETTLE) m_state = 2;
                end
            end
            if (wv && old_state == 2) begin
                s = 32768 + int'($signed(win));
                if (s < WMIN) s = WMIN;
                if (s > WMAX) s = WMAX;
                m_w = s;
            end
        end

        @(posedge clk);
        #1;
        check_eq("state", 32'(state), m_state);
        check_eq("f", 32'(f), m_f);
        check_eq("interp_en", 32'(interpolator_en), m_ie);
        check_eq("symbol_strobe", 32'(symbol_strobe), m_sym);
        check_eq("mid_strobe", 32'(mid_strobe), m_mid);
        check_eq("eta", 32'(dut.eta_q), m_eta);
        check_eq("w", 32'(dut.w_q), m_w);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, en_cur, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic sample_spaced(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, en_cur, 1'b1, 1'b0, 16'h0000);
            idle(9);
        end
    endtask

    initial begin
        // Reset held two clocks while samples are offered.
        en_cur = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_f", 32'(f), 0);

        // Nominal run: IDLE -> SETTLE, then spaced samples.
        idle(1);
        check_eq("settle_entry", 32'(state), 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("nom_eta1", 32'(dut.eta_q), 'h7FFF);
        check_eq("nom_ie1", 32'(interpolator_en), 0);
        idle(9);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("nom_ie2", 32'(interpolator_en), 1);
        check_eq("nom_f2", 32'(f), 'hFFFE);
        check_eq("nom_settle_quiet", 32'(symbol_strobe | mid_strobe), 0);
        idle(9);
        sample_spaced(5);
        check_eq("nom_pre_track", 32'(state), 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("nom_track", 32'(state), 2);
        idle(9);
        sample_spaced(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("nom_sym_first", 32'(symbol_strobe), 1);
        idle(9);
        sample_spaced(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("nom_mid_second", 32'(mid_strobe), 1);

        // Step clamp in TRACK.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h1000);
        check_eq("clamp_9000", 32'(dut.w_q), 'h9000);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h4000);
        check_eq("clamp_hi", 32'(dut.w_q), 'hA000);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hD000);
        check_eq("clamp_lo", 32'(dut.w_q), 'h6000);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);

        // Coincident w_valid and sample: old step used, new step from next sample.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("sim_eta_pre", 32'(dut.eta_q), 'h7FFF);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1000);
        check_eq("sim_eta", 32'(dut.eta_q), 'hFFFF);
        check_eq("sim_ie", 32'(interpolator_en), 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("sim_eta_next", 32'(dut.eta_q), 'h6FFF);

        // Stop in TRACK, then restart.
        en_cur = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("stop_state", 32'(state), 0);
        check_eq("stop_f", 32'(f), 0);
        idle(2);
        en_cur = 1'b1;
        idle(1);
        check_eq("restart_settle", 32'(state), 1);
        sample_spaced(9);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("restart_sym", 32'(symbol_strobe), 1);
        check_eq("restart_mid", 32'(mid_strobe), 0);

        // Reset mid-TRACK on an underflowing sample.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("rsttrk_pre_eta", 32'(dut.eta_q), 'h7FFF);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("rsttrk_ie", 32'(interpolator_en), 0);
        check_eq("rsttrk_state", 32'(state), 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit rst;
            bit en;
            bit sv;
            bit wv;
            logic [15:0] win;
            rst = ($urandom_range(0, 299) != 0);
            en  = ($urandom_range(0, 149) != 0);
            sv  = ($urandom_range(0, 2) == 0);
            wv  = ($urandom_range(0, 7) == 0);
            win = 16'($urandom);
            if ($urandom_range(0, 1) == 0) win = 16'($signed(16'($urandom_range(0, 'h3000))) - 16'sh1800);
            drive(rst, en, sv, wv, win);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
